// File: rtl/mem_req_arbiter.sv
// Arbitrates the DDR2 command path among NREQ requesters. Requester 0 has strict
// priority, the rest share round-robin; a tag FIFO steers two-beat read returns.
module mem_req_arbiter #(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = 31,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_W-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0]     req_wdata,
  input  logic [NREQ*(DATA_W/8)-1:0] req_wmask,
  input  logic                       af_full,
  output logic                       af_wr_en,
  output logic [ADDR_W-1:0]          af_addr_din,
  output logic                       af_wr_n,
  input  logic                       wdf_almost_full,
  output logic                       wdf_wr_en,
  output logic [DATA_W-1:0]          wdf_din,
  output logic [DATA_W/8-1:0]        wdf_mask_din,
  input  logic                       rdf_valid,
  input  logic [DATA_W-1:0]          rdf_dout,
  output logic [NREQ-1:0]            rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       tag_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int PTR_W  = (TAG_DEPTH > 2) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {ST_ARB, ST_WBEAT1} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [IDX_W-1:0]   wsel_reg;
  logic [IDX_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   tag_wr_ptr_reg;
  logic [PTR_W-1:0]   tag_rd_ptr_reg;
  logic [CNT_W-1:0]   tag_count_reg;
  logic               beat_odd_reg;

  logic [NREQ-1:0]    eligible;
  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  logic               grant_we;
  logic               tag_full;
  logic               tag_empty;
  logic               tag_push;
  logic               tag_pop;
  logic               beat_ok;
  logic [NREQ-1:0]    head_onehot;

  assign tag_full  = (tag_count_reg == CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_count_reg == '0);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
      assign eligible[gi] = (state_reg == ST_ARB) && req_valid[gi] && !af_full &&
                            (req_we[gi] ? !wdf_almost_full : !tag_full);
    end
  endgenerate

  // Round-robin search runs over 1..NREQ-1 only, starting just after rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    if (eligible[0]) begin
      grant_any = 1'b1;
    end else begin
      for (int k = 1; k < NREQ; k++) begin
        cand = int'(rr_ptr_reg) + k;
        if (cand > NREQ - 1) cand = cand - (NREQ - 1);
        cand_idx = IDX_W'(cand);
        if (!grant_any && eligible[cand_idx]) begin
          grant_any = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
  end

  assign req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;
  assign grant_we  = req_we[grant_idx];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg    <= ST_ARB;
      rr_ptr_reg   <= IDX_W'(NREQ - 1);
      wsel_reg     <= '0;
      af_wr_en     <= 1'b0;
      af_addr_din  <= '0;
      af_wr_n      <= 1'b1;
      wdf_wr_en    <= 1'b0;
      wdf_din      <= '0;
      wdf_mask_din <= '0;
    end else begin
      af_wr_en  <= 1'b0;
      wdf_wr_en <= 1'b0;
      case (state_reg)
        ST_ARB: begin
          if (grant_any) begin
            af_wr_en    <= 1'b1;
            af_addr_din <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            af_wr_n     <= !grant_we;
            if (grant_idx != '0) rr_ptr_reg <= grant_idx;
            if (grant_we) begin
              wdf_wr_en    <= 1'b1;
              wdf_din      <= req_wdata[grant_idx*DATA_W +: DATA_W];
              wdf_mask_din <= req_wmask[grant_idx*MASK_W +: MASK_W];
              wsel_reg     <= grant_idx;
              state_reg    <= ST_WBEAT1;
            end
          end
        end
        ST_WBEAT1: begin
          // Beat1 is taken unconditionally; the FIFO flags leave enough slack.
          wdf_wr_en    <= 1'b1;
          wdf_din      <= req_wdata[wsel_reg*DATA_W +: DATA_W];
          wdf_mask_din <= req_wmask[wsel_reg*MASK_W +: MASK_W];
          state_reg    <= ST_ARB;
        end
        default: state_reg <= ST_ARB;
      endcase
    end
  end

  assign tag_push    = grant_any && !grant_we;
  assign beat_ok     = rdf_valid && !tag_empty;
  assign tag_pop     = beat_ok && beat_odd_reg;
  assign head_onehot = NREQ'(1) << tag_mem[tag_rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_ptr_reg] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      tag_count_reg  <= '0;
      beat_odd_reg   <= 1'b0;
      rd_valid       <= '0;
      rd_data        <= '0;
      tag_err        <= 1'b0;
    end else begin
      rd_valid <= beat_ok ? head_onehot : '0;
      if (beat_ok) begin
        rd_data      <= rdf_dout;
        beat_odd_reg <= !beat_odd_reg;
      end
      if (rdf_valid && tag_empty) tag_err <= 1'b1;
      if (tag_push) tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
      if (tag_pop)  tag_rd_ptr_reg <= tag_rd_ptr_reg + 1'b1;
      case ({tag_push, tag_pop})
        2'b10:   tag_count_reg <= tag_count_reg + 1'b1;
        2'b01:   tag_count_reg <= tag_count_reg - 1'b1;
        default: tag_count_reg <= tag_count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference model of grants, write beats and read returns.
module tb_mem_req_arbiter;

  localparam int NREQ      = 3;
  localparam int ADDR_W    = 31;
  localparam int DATA_W    = 128;
  localparam int TAG_DEPTH = 8;
  localparam int MW        = DATA_W / 8;

  logic                   clk = 1'b0;
  logic                   rst_b = 1'b1;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*MW-1:0]     req_wmask;
  logic                   af_full;
  logic                   af_wr_en;
  logic [ADDR_W-1:0]      af_addr_din;
  logic                   af_wr_n;
  logic                   wdf_almost_full;
  logic                   wdf_wr_en;
  logic [DATA_W-1:0]      wdf_din;
  logic [MW-1:0]          wdf_mask_din;
  logic                   rdf_valid;
  logic [DATA_W-1:0]      rdf_dout;
  logic [NREQ-1:0]        rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   tag_err;

  mem_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .af_full(af_full), .af_wr_en(af_wr_en), .af_addr_din(af_addr_din), .af_wr_n(af_wr_n),
    .wdf_almost_full(wdf_almost_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din), .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
    .rd_valid(rd_valid), .rd_data(rd_data), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              q[$];
  bit              m_busy;
  int              m_wsel;
  int              m_rr;
  bit              m_half;
  logic [NREQ-1:0] obs_ready;

  logic              exp_af_wr_en;
  logic [ADDR_W-1:0] exp_af_addr;
  logic              exp_af_wr_n;
  logic              exp_wdf_wr_en;
  logic [DATA_W-1:0] exp_wdf_din;
  logic [MW-1:0]     exp_wdf_mask;
  logic [NREQ-1:0]   exp_rd_valid;
  logic [DATA_W-1:0] exp_rd_data;
  logic              exp_tag_err;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r;
  endfunction

  // Requester 0 first; otherwise first eligible of 1..NREQ-1 after rr.
  function automatic int pick(input logic [NREQ-1:0] elig, input int rr);
    if (elig[0]) return 0;
    for (int k = 1; k < NREQ; k++) begin
      int c;
      c = (rr - 1 + k) % (NREQ - 1) + 1;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_wsel = 0; m_rr = NREQ - 1; m_half = 0;
    exp_af_wr_en = 0; exp_af_addr = '0; exp_af_wr_n = 1;
    exp_wdf_wr_en = 0; exp_wdf_din = '0; exp_wdf_mask = '0;
    exp_rd_valid = '0; exp_rd_data = '0; exp_tag_err = 0;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    af_full = 0; wdf_almost_full = 0; rdf_valid = 0; rdf_dout = '0;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MW-1:0] m);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_wmask[i*MW +: MW] = m;
  endtask

  task automatic check_outputs();
    check("af_wr_en", af_wr_en, exp_af_wr_en);
    check("af_addr_din", af_addr_din, exp_af_addr);
    check("af_wr_n", af_wr_n, exp_af_wr_n);
    check("wdf_wr_en", wdf_wr_en, exp_wdf_wr_en);
    check("wdf_din", wdf_din, exp_wdf_din);
    check("wdf_mask_din", wdf_mask_din, exp_wdf_mask);
    check("rd_valid", rd_valid, exp_rd_valid);
    check("rd_data", rd_data, exp_rd_data);
    check("tag_err", tag_err, exp_tag_err);
  endtask

  task automatic do_reset();
    idle();
    rst_b = 0;
    model_reset();
    #2;
    check("rst_req_ready", req_ready, '0);
    check_outputs();
    @(negedge clk);
    rst_b = 1;
    @(posedge clk);
    #1;
  endtask

  // One clock: ready checked mid-cycle, registered outputs just after the edge.
  task automatic cycle();
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] exp_ready;
    int w;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && !af_full && !m_busy &&
                (req_we[i] ? !wdf_almost_full : (q.size() < TAG_DEPTH));
    w = pick(elig, m_rr);
    exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
    obs_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    exp_af_wr_en = 0;
    exp_wdf_wr_en = 0;
    if (m_busy) begin
      exp_wdf_wr_en = 1;
      exp_wdf_din = req_wdata[m_wsel*DATA_W +: DATA_W];
      exp_wdf_mask = req_wmask[m_wsel*MW +: MW];
      m_busy = 0;
    end else if (w >= 0) begin
      exp_af_wr_en = 1;
      exp_af_addr = req_addr[w*ADDR_W +: ADDR_W];
      exp_af_wr_n = !req_we[w];
      if (req_we[w]) begin
        exp_wdf_wr_en = 1;
        exp_wdf_din = req_wdata[w*DATA_W +: DATA_W];
        exp_wdf_mask = req_wmask[w*MW +: MW];
        m_busy = 1;
        m_wsel = w;
      end
      if (w != 0) m_rr = w;
      $display("grant req=%0d we=%0b addr=%0h", w, req_we[w], req_addr[w*ADDR_W +: ADDR_W]);
    end
    exp_rd_valid = '0;
    if (rdf_valid) begin
      if (q.size() > 0) begin
        exp_rd_valid = NREQ'(1) << q[0];
        exp_rd_data = rdf_dout;
        if (m_half) void'(q.pop_front());
        m_half = !m_half;
      end else begin
        exp_tag_err = 1;
      end
    end
    if (w >= 0 && !req_we[w]) q.push_back(w);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] rr_exp [4];
    idle();
    #1;
    do_reset();

    // Single read from requester 1 and its two-beat return
    set_req(1, 1, 0, 31'h0000100, '0, '0);
    cycle();
    check("t1_grant", obs_ready, 3'b010);
    check("t1_af_addr", af_addr_din, 31'h0000100);
    check("t1_af_wr_n", af_wr_n, 1'b1);
    idle();
    rdf_valid = 1; rdf_dout = {32{4'hA}};
    cycle();
    check("t1_rd_valid0", rd_valid, 3'b010);
    check("t1_rd_data0", rd_data, {32{4'hA}});
    rdf_dout = {32{4'hB}};
    cycle();
    check("t1_rd_valid1", rd_valid, 3'b010);
    check("t1_rd_data1", rd_data, {32{4'hB}});
    rdf_valid = 0;
    cycle();

    // Write from requester 2, beat1 presented in the following cycle
    set_req(2, 1, 1, 31'h40, {16{8'h11}}, '0);
    cycle();
    check("t2_grant", obs_ready, 3'b100);
    check("t2_af_wr_n", af_wr_n, 1'b0);
    check("t2_beat0", wdf_din, {16{8'h11}});
    set_req(2, 0, 1, 31'h40, {16{8'h22}}, '0);
    cycle();
    check("t2_no_ready", obs_ready, 3'b000);
    check("t2_beat1_en", wdf_wr_en, 1'b1);
    check("t2_beat1", wdf_din, {16{8'h22}});
    idle();
    cycle();

    // Strict priority, then round-robin between 1 and 2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, ADDR_W'(32'h1000 + i), '0, '0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("prio_grant", obs_ready, 3'b001);
    end
    idle();
    rdf_valid = 1;
    for (int k = 0; k < 12; k++) begin
      rdf_dout = rand_data();
      cycle();
      check("prio_return", rd_valid, 3'b001);
    end
    rdf_valid = 0;
    set_req(1, 1, 0, 31'h2001, '0, '0);
    set_req(2, 1, 0, 31'h2002, '0, '0);
    rr_exp = '{3'b010, 3'b100, 3'b010, 3'b100};
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("rr_grant", obs_ready, rr_exp[k]);
    end
    idle();

    // Tag FIFO full: reads stall, writes still go
    do_reset();
    for (int k = 0; k < TAG_DEPTH; k++) begin
      set_req(1, 1, 0, ADDR_W'(32'h200 + k), '0, '0);
      cycle();
      check("fill_grant", obs_ready, 3'b010);
    end
    set_req(2, 1, 1, 31'h300, rand_data(), 16'h00FF);
    cycle();
    check("full_write", obs_ready, 3'b100);
    set_req(2, 0, 1, 31'h300, rand_data(), 16'hFF00);
    cycle();
    rdf_valid = 1; rdf_dout = rand_data();
    cycle();
    check("full_beat0", obs_ready, 3'b000);
    rdf_dout = rand_data();
    cycle();
    check("full_beat1", obs_ready, 3'b000);
    rdf_valid = 0;
    cycle();
    check("after_pop", obs_ready, 3'b010);
    idle();
    cycle();

    // af_full blocks all; wdf_almost_full blocks only writes
    do_reset();
    set_req(0, 1, 0, 31'h10, '0, '0);
    set_req(1, 1, 1, 31'h11, rand_data(), '1);
    set_req(2, 1, 0, 31'h12, '0, '0);
    af_full = 1;
    cycle();
    check("af_full_block", obs_ready, 3'b000);
    af_full = 0; wdf_almost_full = 1;
    req_valid[0] = 0;
    cycle();
    check("wdf_read_ok", obs_ready, 3'b100);
    req_valid[2] = 0;
    cycle();
    check("wdf_write_blk", obs_ready, 3'b000);
    idle();
    cycle();

    // Reset in the middle of a return leaves the next beat orphaned
    do_reset();
    set_req(1, 1, 0, 31'h500, '0, '0);
    cycle();
    cycle();
    idle();
    rdf_valid = 1; rdf_dout = rand_data();
    cycle();
    check("mid_rd_valid", rd_valid, 3'b010);
    do_reset();
    rdf_valid = 1; rdf_dout = rand_data();
    cycle();
    check("orphan_rd_valid", rd_valid, 3'b000);
    check("orphan_tag_err", tag_err, 1'b1);
    rdf_valid = 0;
    cycle();
    check("tag_err_sticky", tag_err, 1'b1);

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 1), $urandom_range(0, 1), ADDR_W'($urandom()),
                rand_data(), MW'($urandom()));
      af_full = ($urandom_range(0, 7) == 0);
      wdf_almost_full = ($urandom_range(0, 5) == 0);
      rdf_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      rdf_dout = rand_data();
      cycle();
    end
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single DDR2 request-controller command path among NREQ requesters: address FIFO (af), write-data FIFO (wdf) and read-data FIFO (rdf).
- Typical requesters are PixelFeeder, the filler/line engines and the CPU cache bypass.
- Requester 0 (PixelFeeder, real-time) has strict priority. The others share the remaining slots round-robin.
- A tag FIFO routes in-order read returns back to the requester that issued each read.

Parameters:
NREQ, 3, number of requesters (2..8); index 0 is strict-priority
ADDR_W, 31, DDR address width
DATA_W, 128, FIFO data beat width
TAG_DEPTH, 8, max outstanding reads (power of 2)

Ports:
clk  in  1  single system clock
rst_b  in  1  asynchronous active-low reset
req_valid  in  NREQ  command request per requester
req_ready  out  NREQ  command accept (combinational)
req_we  in  NREQ  1=write, 0=read
req_addr  in  NREQ*ADDR_W  flattened; slice i = requester i
req_wdata  in  NREQ*DATA_W  write beat: beat0 in accept cycle, beat1 in next cycle
req_wmask  in  NREQ*(DATA_W/8)  byte mask per beat, same timing as req_wdata
af_full  in  1  address FIFO almost-full (>=2 free slots while low)
af_wr_en  out  1  address FIFO push
af_addr_din  out  ADDR_W  command address
af_wr_n  out  1  0=write, 1=read
wdf_almost_full  in  1  wdf has <2 free entries
wdf_wr_en  out  1  write-data push
wdf_din  out  DATA_W  write beat
wdf_mask_din  out  DATA_W/8  byte mask
rdf_valid  in  1  read beat available (2 beats per read)
rdf_dout  in  DATA_W  read beat
rd_valid  out  NREQ  one-hot return strobe
rd_data  out  DATA_W  registered copy of rdf_dout
tag_err  out  1  sticky: rdf beat arrived with tag FIFO empty

Behaviour:
- Reset (rst_b low, async): all outputs 0 except af_wr_n=1; state=ARB; rr_ptr=NREQ-1; tag FIFO empty; tag_err=0.
- Two states:
  - ARB: at most one grant per cycle.
  - WBEAT1: entered on a write grant; lasts exactly 1 cycle, then returns to ARB. No grants in WBEAT1.
- Grant eligibility for requester i in ARB requires:
  - req_valid[i] and !af_full;
  - for a read: tag count < TAG_DEPTH;
  - for a write: !wdf_almost_full.
- Selection:
  - If requester 0 is eligible it wins.
  - Otherwise search 1..NREQ-1 starting at rr_ptr+1 (wrapping 1..NREQ-1) and pick the first eligible.
  - rr_ptr updates to the winner only when the winner is non-zero.
- req_ready is one-hot or zero and asserted only for the winner. Accept = req_valid & req_ready (cycle N).
- Cycle N+1 outputs:
  - af_wr_en=1; af_addr_din and af_wr_n=!req_we are registered from the winner.
  - On a write, also wdf_wr_en=1 with the beat0 data/mask captured at N.
- Writes: beat1 is captured from the same requester's req_wdata/req_wmask at N+1 (WBEAT1) and pushed at N+2. The requester must hold beat1 at N+1 regardless of req_valid.
- Reads: the winner id is pushed into the tag FIFO at N. Back-to-back read grants every cycle are allowed.
- Throughput: one write per 2 cycles.
- Returns:
  - Each rdf_valid beat is registered: rd_data <= rdf_dout, rd_valid <= onehot(tag head), one cycle later.
  - A beat counter toggles per beat; the tag is popped on the second beat.
  - A push and pop in the same cycle leave the count unchanged.
  - A push while the FIFO is full cannot occur (blocked by eligibility).
- rdf_valid with the tag FIFO empty: the beat is dropped, rd_valid stays 0, and tag_err is set until reset.
- af_full or wdf_almost_full rising during WBEAT1 does not cancel beat1; the slack guaranteed by those flags covers it.
- Reset mid-operation clears pending beat1 and all tags. In-flight returns are then flagged via tag_err; the top level resets the MIG alongside.

Test Plan:
- Single read, requester 1, addr 0x0000100:
  - af_wr_en=1 with af_addr_din=0x0000100, af_wr_n=1 one cycle after accept.
  - Two rdf beats 0xA.., 0xB.. -> rd_valid=3'b010 twice, with matching rd_data one cycle after each beat.
- Write, requester 2, addr 0x40, beats 0x11../0x22.., mask 0:
  - af_wr_n=0.
  - wdf_wr_en at N+1 (0x11..) and N+2 (0x22..).
  - req_ready all 0 at N+1.
- Requesters 0, 1, 2 all reading continuously for 6 cycles -> grants 0,0,0,0,0,0. Then drop req 0 -> grants 1,2,1,2.
- 8 reads outstanding (TAG_DEPTH=8), further read request -> req_ready=0 until the second return beat, then granted next cycle. A write request is still granted while the tag FIFO is full.
- af_full=1 -> no req_ready for any requester. wdf_almost_full=1 -> writes blocked while reads still granted.
- Issue 2 reads, assert rst_b=0 mid-return, release, then deliver 1 rdf beat -> rd_valid stays 0 and tag_err=1.
